// File: rtl/at_chunk_tx.sv
// AT-command frame transmitter: splits a latched payload into chunks, frames each
// chunk as HDR + bytes + TRL + CR LF, and waits for OK/ERROR with retry on failure.
//
//   state    | meaning
//   IDLE     | waiting for data_valid; also clears busy/chunk_idx after done/fail
//   HDR      | sending header bytes
//   PAY      | sending the current chunk's payload bytes
//   TRL      | sending trailer bytes
//   EOL      | sending CR then LF
//   WAIT_ACK | waiting for ack_ok/ack_err or timeout
//   FIN      | pulsing done
module at_chunk_tx #(
  parameter int PAYLOAD_BYTES = 640,
  parameter int CHUNK_BYTES = 256,
  parameter int HDR_LEN = 4,
  parameter logic [HDR_LEN*8-1:0] HDR = "AT+S",
  parameter int TRL_LEN = 2,
  parameter logic [TRL_LEN*8-1:0] TRL = "\"}",
  parameter int ACK_TIMEOUT = 50000000,
  parameter int MAX_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PAYLOAD_BYTES*8-1:0] data_in,
  input  logic                       data_valid,
  input  logic                       tx_ready,
  input  logic                       ack_ok,
  input  logic                       ack_err,
  output logic [7:0]                 data_out,
  output logic                       data_out_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [15:0]                chunk_idx
);

  localparam int CLEN = (CHUNK_BYTES < PAYLOAD_BYTES) ? CHUNK_BYTES : PAYLOAD_BYTES;
  localparam int M1 = (HDR_LEN > TRL_LEN) ? HDR_LEN : TRL_LEN;
  localparam int M2 = (M1 > CLEN) ? M1 : CLEN;
  localparam int MAXL = (M2 > 2) ? M2 : 2;
  localparam int CW = $clog2(PAYLOAD_BYTES + MAXL + 1) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAY, S_TRL, S_EOL, S_WAIT_ACK, S_FIN
  } state_t;

  state_t                     state, adv_state, ld_state;
  logic [PAYLOAD_BYTES*8-1:0] payload_q;
  logic [CW-1:0]              pos, offset_q, rem, pay_len, sec_len, adv_pos, ld_pos, pay_idx;
  logic [TW-1:0]              timer;
  logic [RW-1:0]              retry;
  logic                       last_chunk, sec_end;
  logic [7:0]                 ld_byte, hdr_b, trl_b, pay_b;

  assign rem        = CW'(PAYLOAD_BYTES) - offset_q;
  assign pay_len    = (rem < CW'(CLEN)) ? rem : CW'(CLEN);
  assign last_chunk = (rem <= CW'(CLEN));

  // ld_* is the byte to present next: the current slot when nothing is presented
  // yet, otherwise the slot following the byte being accepted.
  always_comb begin
    case (state)
      S_HDR:   sec_len = CW'(HDR_LEN);
      S_PAY:   sec_len = pay_len;
      S_TRL:   sec_len = CW'(TRL_LEN);
      default: sec_len = CW'(2);
    endcase
    sec_end   = (pos == sec_len - CW'(1));
    adv_state = state;
    adv_pos   = pos + CW'(1);
    if (sec_end) begin
      adv_pos = '0;
      case (state)
        S_HDR:   adv_state = S_PAY;
        S_PAY:   adv_state = S_TRL;
        S_TRL:   adv_state = S_EOL;
        default: adv_state = state;
      endcase
    end
    ld_state = data_out_valid ? adv_state : state;
    ld_pos   = data_out_valid ? adv_pos : pos;
    pay_idx  = offset_q + ld_pos;
    hdr_b = '0;
    for (int i = 0; i < HDR_LEN; i++)
      if (ld_pos == CW'(i)) hdr_b = HDR[(HDR_LEN-1-i)*8 +: 8];
    trl_b = '0;
    for (int i = 0; i < TRL_LEN; i++)
      if (ld_pos == CW'(i)) trl_b = TRL[(TRL_LEN-1-i)*8 +: 8];
    pay_b = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++)
      if (pay_idx == CW'(i)) pay_b = payload_q[(PAYLOAD_BYTES-1-i)*8 +: 8];
    case (ld_state)
      S_HDR:   ld_byte = hdr_b;
      S_PAY:   ld_byte = pay_b;
      S_TRL:   ld_byte = trl_b;
      default: ld_byte = (ld_pos == '0) ? 8'h0D : 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      payload_q      <= '0;
      pos            <= '0;
      offset_q       <= '0;
      timer          <= '0;
      retry          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      chunk_idx      <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        S_IDLE: begin
          if (busy) begin
            busy      <= 1'b0;
            chunk_idx <= '0;
          end else if (data_valid) begin
            payload_q <= data_in;
            busy      <= 1'b1;
            chunk_idx <= '0;
            offset_q  <= '0;
            retry     <= '0;
            pos       <= '0;
            state     <= S_HDR;
          end
        end
        S_HDR, S_PAY, S_TRL, S_EOL: begin
          if (!data_out_valid) begin
            data_out       <= ld_byte;
            data_out_valid <= 1'b1;
          end else if (tx_ready) begin
            if (state == S_EOL && sec_end) begin
              data_out_valid <= 1'b0;
              timer          <= '0;
              state          <= S_WAIT_ACK;
            end else begin
              state    <= adv_state;
              pos      <= adv_pos;
              data_out <= ld_byte;
            end
          end
        end
        S_WAIT_ACK: begin
          timer <= timer + TW'(1);
          // a simultaneous ok+err is treated as an error
          if (ack_err || timer == TW'(ACK_TIMEOUT - 1)) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + RW'(1);
              pos   <= '0;
              state <= S_HDR;
            end else begin
              fail  <= 1'b1;
              state <= S_IDLE;
            end
          end else if (ack_ok) begin
            if (last_chunk) begin
              state <= S_FIN;
            end else begin
              chunk_idx <= chunk_idx + 16'd1;
              offset_q  <= offset_q + CW'(CLEN);
              retry     <= '0;
              pos       <= '0;
              state     <= S_HDR;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_at_chunk_tx.sv
// Scoreboard bench for at_chunk_tx: expected byte streams are queued at stimulus
// time and a negedge monitor pops and compares each accepted byte.
module tb_at_chunk_tx;
  localparam int P = 5;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [P*8-1:0] data_in = '0;
  logic           data_valid = 1'b0;
  logic           tx_ready = 1'b1;
  logic           ack_ok = 1'b0;
  logic           ack_err = 1'b0;
  logic [7:0]     data_out;
  logic           data_out_valid, busy, done, fail;
  logic [15:0]    chunk_idx;

  int n_cmp = 0, n_bad = 0;
  byte unsigned exp_q[$];
  logic [7:0] exp_pay[P];
  int cyc = 0, lf_cnt = 0, acc_cnt = 0, done_cnt = 0, fail_cnt = 0;
  int last_lf_cyc = 0, fail_cyc = 0, lf_expect = 0;
  bit rand_rdy = 1'b0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  at_chunk_tx #(
    .PAYLOAD_BYTES(P), .CHUNK_BYTES(C),
    .HDR_LEN(2), .HDR(16'h4154),
    .TRL_LEN(1), .TRL(8'h21),
    .ACK_TIMEOUT(10), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .tx_ready(tx_ready), .ack_ok(ack_ok), .ack_err(ack_err),
    .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy),
    .done(done), .fail(fail), .chunk_idx(chunk_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    byte unsigned e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_data", 32'(data_out), 32'(prev_data));
        check("hold_valid", 32'(data_out_valid), 32'd1);
      end
      if (data_out_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none", data_out);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'(data_out), 32'(e));
        end
        if (data_out == 8'h0A) begin
          lf_cnt++;
          last_lf_cyc = cyc;
        end
      end
      if (done) done_cnt++;
      if (fail) begin
        fail_cnt++;
        fail_cyc = cyc;
      end
      prev_hold = data_out_valid && !tx_ready;
      prev_data = data_out;
    end
  end

  task automatic set_payload(input logic [P*8-1:0] d);
    for (int i = 0; i < P; i++) exp_pay[i] = d[(P-1-i)*8 +: 8];
  endtask

  task automatic push_frame(input int ch);
    int off, len;
    off = ch * C;
    len = (P - off < C) ? P - off : C;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h54);
    for (int i = 0; i < len; i++) exp_q.push_back(exp_pay[off + i]);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic start(input logic [P*8-1:0] d);
    lf_expect = lf_cnt;
    @(posedge clk);
    #1 data_in = d;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic wait_lf(input int ch);
    lf_expect++;
    for (int i = 0; i < 400 && lf_cnt < lf_expect; i++) @(posedge clk);
    #1;
    check("lf_seen", 32'(lf_cnt >= lf_expect), 32'd1);
    check("chunk_idx", 32'(chunk_idx), 32'(ch));
  endtask

  task automatic send_ack(input bit ok, input bit err);
    repeat (2) @(posedge clk);
    #1 ack_ok = ok;
    ack_err = err;
    @(posedge clk);
    #1 ack_ok = 1'b0;
    ack_err = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int f0, input int exp_done, input int exp_fail);
    for (int i = 0; i < 40 && (done_cnt - d0) < exp_done + 0 && (fail_cnt - f0) < exp_fail + 0; i++)
      @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("done_count", 32'(done_cnt - d0), 32'(exp_done));
    check("fail_count", 32'(fail_cnt - f0), 32'(exp_fail));
    check("busy_end", 32'(busy), 32'd0);
    check("chunk_idx_end", 32'(chunk_idx), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_ok(input logic [P*8-1:0] d);
    int d0, f0;
    d0 = done_cnt;
    f0 = fail_cnt;
    set_payload(d);
    for (int k = 0; k < 3; k++) push_frame(k);
    start(d);
    for (int k = 0; k < 3; k++) begin
      wait_lf(k);
      send_ack(1'b1, 1'b0);
    end
    wait_end(d0, f0, 1, 0);
  endtask

  initial begin
    int d0, f0;
    #100000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, base;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_fail", 32'({done, fail}), 32'd0);
    check("rst_chunk_idx", 32'(chunk_idx), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // nominal transfer
    run_ok(40'h11_22_33_44_55);

    // random back-pressure
    rand_rdy = 1'b1;
    run_ok(40'h66_77_88_99_AB);
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);

    // one ERROR on chunk 1
    d0 = done_cnt;
    f0 = fail_cnt;
    set_payload(40'h01_02_03_04_05);
    push_frame(0); push_frame(1); push_frame(1); push_frame(2);
    start(40'h01_02_03_04_05);
    wait_lf(0); send_ack(1'b1, 1'b0);
    wait_lf(1); send_ack(1'b0, 1'b1);
    wait_lf(1); send_ack(1'b1, 1'b0);
    wait_lf(2); send_ack(1'b1, 1'b0);
    wait_end(d0, f0, 1, 0);

    // no ack at all: two timeouts retried, third aborts
    d0 = done_cnt;
    f0 = fail_cnt;
    set_payload(40'hC1_C2_C3_C4_C5);
    push_frame(0); push_frame(0); push_frame(0);
    start(40'hC1_C2_C3_C4_C5);
    wait_lf(0); wait_lf(0); wait_lf(0);
    for (int i = 0; i < 40 && fail_cnt == f0; i++) @(posedge clk);
    check("timeout_gap", 32'(fail_cyc - last_lf_cyc), 32'd11);
    wait_end(d0, f0, 0, 1);

    // ok+err together counts as error; data_valid while busy is ignored
    d0 = done_cnt;
    f0 = fail_cnt;
    set_payload(40'h31_32_33_34_35);
    push_frame(0); push_frame(0); push_frame(1); push_frame(2);
    start(40'h31_32_33_34_35);
    @(posedge clk);
    #1 data_in = 40'hEE_EE_EE_EE_EE;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    wait_lf(0); send_ack(1'b1, 1'b1);
    wait_lf(0); send_ack(1'b1, 1'b0);
    wait_lf(1); send_ack(1'b1, 1'b0);
    wait_lf(2); send_ack(1'b1, 1'b0);
    wait_end(d0, f0, 1, 0);

    // reset during PAY, then a clean restart
    d0 = done_cnt;
    f0 = fail_cnt;
    set_payload(40'h51_52_53_54_55);
    push_frame(0);
    base = acc_cnt;
    start(40'h51_52_53_54_55);
    for (int i = 0; i < 40 && acc_cnt < base + 3; i++) @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(data_out_valid), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_chunk", 32'(chunk_idx), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_rst_no_pulse", 32'(done_cnt - d0 + fail_cnt - f0), 32'd0);
    run_ok(40'hA1_B2_C3_D4_E5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
